reg_file: RTL and testbench

Architectural register file with rename tags, sitting directly downstream of the reorder buffer. It holds x0–x31 committed values plus a per-register busy bit and ROB tag, updated by the ROB's issue-pollution and commit outputs. It resolves the decoder's two source operands each cycle into a ready value or a pending ROB tag, consulting the ROB's entry-query port when a register is renamed.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_operand_resolve.sv | 73 +++++++
 rtl/reg_file.sv | 118 +++++++++++
 tb/tb_reg_file.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural register file and its operand resolvers.
package reg_file_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned RobBitDefault = 4;
    localparam int unsigned RegBitDefault = 5;

    // Where a resolved source operand gets its value from, in priority order.
    typedef enum logic [2:0] {
        SrcZero,
        SrcFile,
        SrcBypass,
        SrcRob,
        SrcPending
    } operand_src_e;

endpackage

// File: rtl/reg_operand_resolve.sv
// Combinational priority mux resolving one source operand to a value or a pending ROB tag.
// REG_COMMIT_BYPASS_EN adds a direct forward from the commit bus ahead of the ROB query.
module reg_operand_resolve
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_BIT = RobBitDefault,
    parameter int unsigned REG_BIT = RegBitDefault
) (
    input  logic [REG_BIT-1:0] id_i,
    input  logic               busy_i,
    input  logic [ROB_BIT-1:0] tag_i,
    input  logic [XLEN-1:0]    val_i,
    input  logic               commit_i,
    input  logic [REG_BIT-1:0] commit_rd_i,
    input  logic [ROB_BIT-1:0] commit_entry_i,
    input  logic [XLEN-1:0]    commit_value_i,
    input  logic               rob_ready_i,
    input  logic [XLEN-1:0]    rob_value_i,
    output logic               ready_o,
    output logic [XLEN-1:0]    value_o,
    output logic [ROB_BIT-1:0] rob_entry_o
);

    operand_src_e src;

`ifdef REG_COMMIT_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = commit_i && (commit_rd_i == id_i) && (commit_entry_i == tag_i);
`else
    logic unused_commit;
    assign unused_commit = ^{commit_i, commit_rd_i, commit_entry_i, commit_value_i};
`endif

    always_comb begin
        src = SrcPending;
        if (id_i == '0) begin
            src = SrcZero;
        end else if (!busy_i) begin
            src = SrcFile;
`ifdef REG_COMMIT_BYPASS_EN
        end else if (bypass_hit) begin
            src = SrcBypass;
`endif
        end else if (rob_ready_i) begin
            src = SrcRob;
        end
    end

    always_comb begin
        ready_o     = 1'b0;
        value_o     = '0;
        rob_entry_o = '0;
        case (src)
            SrcZero: ready_o = 1'b1;
            SrcFile: begin
                ready_o = 1'b1;
                value_o = val_i;
            end
`ifdef REG_COMMIT_BYPASS_EN
            SrcBypass: begin
                ready_o = 1'b1;
                value_o = commit_value_i;
            end
`endif
            SrcRob: begin
                ready_o = 1'b1;
                value_o = rob_value_i;
            end
            default: rob_entry_o = tag_i;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and ROB rename tag.
// REG_COMMIT_BYPASS_EN (passed to the resolvers) forwards matching commits straight to operands.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_BIT = RobBitDefault,
    parameter int unsigned REG_BIT = RegBitDefault
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_up,
    input  logic               issue_pollute,
    input  logic [REG_BIT-1:0] issue_reg_id,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               rob_commit,
    input  logic [REG_BIT-1:0] commit_rd_reg_id,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [XLEN-1:0]    commit_value,
    input  logic [REG_BIT-1:0] rs1_id,
    input  logic [REG_BIT-1:0] rs2_id,
    output logic               rs1_ready,
    output logic               rs2_ready,
    output logic [XLEN-1:0]    rs1_value,
    output logic [XLEN-1:0]    rs2_value,
    output logic [ROB_BIT-1:0] rs1_rob_entry,
    output logic [ROB_BIT-1:0] rs2_rob_entry,
    output logic [ROB_BIT-1:0] get_rob_entry1,
    output logic [ROB_BIT-1:0] get_rob_entry2,
    input  logic               ready1,
    input  logic               ready2,
    input  logic [XLEN-1:0]    value1,
    input  logic [XLEN-1:0]    value2
);

    localparam int unsigned NumRegs = 2 ** REG_BIT;

    logic [XLEN-1:0]    val_q [NumRegs];
    logic [XLEN-1:0]    val_d [NumRegs];
    logic [ROB_BIT-1:0] tag_q [NumRegs];
    logic [ROB_BIT-1:0] tag_d [NumRegs];
    logic [NumRegs-1:0] busy_q, busy_d;

    // Index 0 is never written, so x0 stays idle with tag 0.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rob_commit && commit_rd_reg_id != '0) begin
            val_d[commit_rd_reg_id] = commit_value;
            if (tag_q[commit_rd_reg_id] == commit_rob_entry) begin
                busy_d[commit_rd_reg_id] = 1'b0;
            end
        end
        if (clear_up) begin
            busy_d = '0;
        end else if (issue_pollute && issue_reg_id != '0) begin
            busy_d[issue_reg_id] = 1'b1;
            tag_d[issue_reg_id]  = issue_rob_entry;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            busy_q <= busy_d;
            val_q  <= val_d;
            tag_q  <= tag_d;
        end
    end

    assign get_rob_entry1 = tag_q[rs1_id];
    assign get_rob_entry2 = tag_q[rs2_id];

    reg_operand_resolve #(
        .ROB_BIT(ROB_BIT),
        .REG_BIT(REG_BIT)
    ) u_resolve_rs1 (
        .id_i          (rs1_id),
        .busy_i        (busy_q[rs1_id]),
        .tag_i         (tag_q[rs1_id]),
        .val_i         (val_q[rs1_id]),
        .commit_i      (rob_commit),
        .commit_rd_i   (commit_rd_reg_id),
        .commit_entry_i(commit_rob_entry),
        .commit_value_i(commit_value),
        .rob_ready_i   (ready1),
        .rob_value_i   (value1),
        .ready_o       (rs1_ready),
        .value_o       (rs1_value),
        .rob_entry_o   (rs1_rob_entry)
    );

    reg_operand_resolve #(
        .ROB_BIT(ROB_BIT),
        .REG_BIT(REG_BIT)
    ) u_resolve_rs2 (
        .id_i          (rs2_id),
        .busy_i        (busy_q[rs2_id]),
        .tag_i         (tag_q[rs2_id]),
        .val_i         (val_q[rs2_id]),
        .commit_i      (rob_commit),
        .commit_rd_i   (commit_rd_reg_id),
        .commit_entry_i(commit_rob_entry),
        .commit_value_i(commit_value),
        .rob_ready_i   (ready2),
        .rob_value_i   (value2),
        .ready_o       (rs2_ready),
        .value_o       (rs2_value),
        .rob_entry_o   (rs2_rob_entry)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed scoreboard bench for reg_file: expected operand results are queued with each step.
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_up;
    logic        issue_pollute;
    logic [4:0]  issue_reg_id;
    logic [3:0]  issue_rob_entry;
    logic        rob_commit;
    logic [4:0]  commit_rd_reg_id;
    logic [3:0]  commit_rob_entry;
    logic [31:0] commit_value;
    logic [4:0]  rs1_id, rs2_id;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_value, rs2_value;
    logic [3:0]  rs1_rob_entry, rs2_rob_entry;
    logic [3:0]  get_rob_entry1, get_rob_entry2;
    logic        ready1, ready2;
    logic [31:0] value1, value2;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        r1;
        logic [31:0] v1;
        logic [3:0]  e1;
        logic [3:0]  g1;
        logic        r2;
        logic [31:0] v2;
        logic [3:0]  e2;
        logic [3:0]  g2;
    } exp_t;

    exp_t sb[$];

    reg_file dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_up        (clear_up),
        .issue_pollute   (issue_pollute),
        .issue_reg_id    (issue_reg_id),
        .issue_rob_entry (issue_rob_entry),
        .rob_commit      (rob_commit),
        .commit_rd_reg_id(commit_rd_reg_id),
        .commit_rob_entry(commit_rob_entry),
        .commit_value    (commit_value),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_ready       (rs1_ready),
        .rs2_ready       (rs2_ready),
        .rs1_value       (rs1_value),
        .rs2_value       (rs2_value),
        .rs1_rob_entry   (rs1_rob_entry),
        .rs2_rob_entry   (rs2_rob_entry),
        .get_rob_entry1  (get_rob_entry1),
        .get_rob_entry2  (get_rob_entry2),
        .ready1          (ready1),
        .ready2          (ready2),
        .value1          (value1),
        .value2          (value2)
    );

    always #5 clk_in = ~clk_in;

    task automatic cmp(input string name, input string field, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", name, field, obs, exp);
        end
    endtask

    task automatic expect_ops(input logic r1, input logic [31:0] v1, input logic [3:0] e1,
                              input logic [3:0] g1, input logic r2, input logic [31:0] v2,
                              input logic [3:0] e2, input logic [3:0] g2);
        exp_t e;
        e.r1 = r1; e.v1 = v1; e.e1 = e1; e.g1 = g1;
        e.r2 = r2; e.v2 = v2; e.e2 = e2; e.g2 = g2;
        sb.push_back(e);
    endtask

    task automatic check_ops(input string name);
        exp_t e;
        e = sb.pop_front();
        cmp(name, "rs1_ready", {31'd0, rs1_ready}, {31'd0, e.r1});
        cmp(name, "rs1_value", rs1_value, e.v1);
        cmp(name, "rs1_rob_entry", {28'd0, rs1_rob_entry}, {28'd0, e.e1});
        cmp(name, "get_rob_entry1", {28'd0, get_rob_entry1}, {28'd0, e.g1});
        cmp(name, "rs2_ready", {31'd0, rs2_ready}, {31'd0, e.r2});
        cmp(name, "rs2_value", rs2_value, e.v2);
        cmp(name, "rs2_rob_entry", {28'd0, rs2_rob_entry}, {28'd0, e.e2});
        cmp(name, "get_rob_entry2", {28'd0, get_rob_entry2}, {28'd0, e.g2});
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_pollute   = 1'b1;
        issue_reg_id    = rd;
        issue_rob_entry = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
        rob_commit       = 1'b1;
        commit_rd_reg_id = rd;
        commit_rob_entry = tag;
        commit_value     = v;
    endtask

    // Advance one clock edge, then drop all single-cycle strobes.
    task automatic tick();
        @(posedge clk_in);
        #1;
        issue_pollute = 1'b0;
        rob_commit    = 1'b0;
        clear_up      = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_up = 1'b0;
        issue_pollute = 1'b0; issue_reg_id = '0; issue_rob_entry = '0;
        rob_commit = 1'b0; commit_rd_reg_id = '0; commit_rob_entry = '0; commit_value = '0;
        rs1_id = '0; rs2_id = '0; ready1 = 1'b0; ready2 = 1'b0; value1 = '0; value2 = '0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        rs1_id = 5; rs2_id = 0; #1;
        expect_ops(1, 0, 0, 0, 1, 0, 0, 0); check_ops("reset");

        issue(5, 3); tick();
        ready1 = 1'b0; #1;
        expect_ops(0, 0, 3, 3, 1, 0, 0, 0); check_ops("pending");
        ready1 = 1'b1; value1 = 32'h1234; #1;
        expect_ops(1, 32'h1234, 0, 3, 1, 0, 0, 0); check_ops("rob_forward");

        // Commit tag 3 and re-rename x5 to tag 7 in one cycle.
        commit(5, 3, 32'hAB); issue(5, 7); value1 = 32'hAB; #1;
        expect_ops(1, 32'hAB, 0, 3, 1, 0, 0, 0); check_ops("commit_cycle");
        tick();
        ready1 = 1'b0; #1;
        expect_ops(0, 0, 7, 7, 1, 0, 0, 0); check_ops("issue_wins");

        issue(6, 2); tick();
        issue(6, 4); tick();
        commit(6, 2, 32'd9); rs1_id = 6; #1;
        expect_ops(0, 0, 4, 4, 1, 0, 0, 0); check_ops("stale_same_cycle");
        tick(); #1;
        expect_ops(0, 0, 4, 4, 1, 0, 0, 0); check_ops("stale_after");

        rdy_in = 1'b0; issue(9, 5); tick();
        rdy_in = 1'b1; rs1_id = 9; #1;
        expect_ops(1, 0, 0, 0, 1, 0, 0, 0); check_ops("rdy_low_frozen");

        issue(1, 8); tick();
        issue(2, 9); tick();
        issue(3, 10); tick();
        rs1_id = 3; #1;
        expect_ops(0, 0, 10, 10, 1, 0, 0, 0); check_ops("pre_flush");
        clear_up = 1'b1; issue(4, 12); commit(3, 10, 32'h33); tick();
        rs1_id = 1; rs2_id = 2; #1;
        expect_ops(1, 0, 0, 8, 1, 0, 0, 9); check_ops("flush_x1_x2");
        rs1_id = 3; rs2_id = 4; #1;
        expect_ops(1, 32'h33, 0, 10, 1, 0, 0, 0); check_ops("flush_x3_x4");
        rs1_id = 5; rs2_id = 6; #1;
        expect_ops(1, 32'hAB, 0, 7, 1, 32'd9, 0, 4); check_ops("flush_x5_x6");

        rs2_id = 0;
        issue(8, 1); tick();
        commit(8, 1, 32'h55); rs1_id = 8; ready1 = 1'b0; #1;
`ifdef REG_COMMIT_BYPASS_EN
        expect_ops(1, 32'h55, 0, 1, 1, 0, 0, 0);
`else
        expect_ops(0, 0, 1, 1, 1, 0, 0, 0);
`endif
        check_ops("bypass");
        tick(); #1;
        expect_ops(1, 32'h55, 0, 1, 1, 0, 0, 0); check_ops("bypass_after");

        issue(0, 6); commit(0, 0, 32'h77); rs1_id = 0; rs2_id = 0; #1;
        expect_ops(1, 0, 0, 0, 1, 0, 0, 0); check_ops("x0_write_cycle");
        tick(); #1;
        expect_ops(1, 0, 0, 0, 1, 0, 0, 0); check_ops("x0_after");

        issue(10, 2); tick();
        rs1_id = 10; rs2_id = 5; #1;
        expect_ops(0, 0, 2, 2, 1, 32'hAB, 0, 7); check_ops("pre_reset");
        rdy_in = 1'b0; #2;
        rst_in = 1'b1; #1;
        expect_ops(1, 0, 0, 0, 1, 0, 0, 0); check_ops("async_reset");
        rst_in = 1'b0; rdy_in = 1'b1;
        repeat (2) @(posedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
